// File: rtl/nv_pipe_muxn.sv
// NCH-way registered multiplexer with valid/ready on every input and on the output.
// The channel is picked by an explicit select (MODE=0) or by a round-robin arbiter (MODE=1).
module nv_pipe_muxn #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [NCH-1:0]        in_pvld,
  output logic [NCH-1:0]        in_prdy,
  input  logic [NCH*WIDTH-1:0]  in_pd,
  input  logic [SELW-1:0]       sel,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [WIDTH-1:0]      out_pd,
  output logic [SELW-1:0]       out_sel
);

  // Handshake: a beat moves on a rising edge when pvld and prdy are both high;
  // prdy never depends on the same channel's pvld in MODE=0, only on load_en and the choice.
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic             load_en;
  logic             choice_exists;
  logic [SELW-1:0]  chosen;
  logic [SELW:0]    scan;
  logic [SELW-1:0]  rr_ptr;
  logic             take;
  logic [WIDTH-1:0] sel_pd;

  // Reset gates load_en so no channel sees ready while the block is held in reset.
  assign load_en = nvdla_core_rstn & (~out_pvld | out_prdy);

  always_comb begin
    choice_exists = 1'b0;
    chosen        = '0;
    scan          = '0;
    if (MODE == 0) begin
      chosen        = sel;
      choice_exists = ({1'b0, sel} < NCH_W);
    end else begin
      for (int k = 0; k < NCH; k++) begin
        scan = {1'b0, rr_ptr} + (SELW+1)'(k);
        if (scan >= NCH_W) scan = scan - NCH_W;
        for (int i = 0; i < NCH; i++) begin
          if (!choice_exists && in_pvld[i] && (scan == (SELW+1)'(i))) begin
            choice_exists = 1'b1;
            chosen        = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    in_prdy = '0;
    sel_pd  = '0;
    for (int i = 0; i < NCH; i++) begin
      in_prdy[i] = load_en & choice_exists & (chosen == SELW'(i));
      if (in_prdy[i]) sel_pd = in_pd[i*WIDTH +: WIDTH];
    end
  end

  assign take = |(in_pvld & in_prdy);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pvld <= 1'b0;
      out_pd   <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
    end else if (load_en) begin
      out_pvld <= take;
      if (take) begin
        out_pd  <= sel_pd;
        out_sel <= chosen;
        if (MODE == 1) rr_ptr <= (chosen == SELW'(NCH-1)) ? '0 : chosen + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nv_pipe_muxn.sv
// Bench for nv_pipe_muxn: select-mode (4 and 3 channels) and round-robin instances
// checked against directed expectations and a queue-based reference model.
module tb_nv_pipe_muxn;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  // Instance A: MODE=0, NCH=4
  logic [3:0]   a_vld, a_rdy;
  logic [127:0] a_pd;
  logic [1:0]   a_sel, a_osel;
  logic         a_ovld, a_ordy;
  logic [31:0]  a_opd;
  logic [33:0]  a_q[$];

  // Instance B: MODE=0, NCH=3 (select value 3 is out of range)
  logic [2:0]   b_vld, b_rdy;
  logic [95:0]  b_pd;
  logic [1:0]   b_sel, b_osel;
  logic         b_ovld, b_ordy;
  logic [31:0]  b_opd;

  // Instance C: MODE=1, NCH=4
  logic [3:0]   c_vld, c_rdy;
  logic [127:0] c_pd;
  logic [1:0]   c_sel, c_osel;
  logic         c_ovld, c_ordy;
  logic [31:0]  c_opd;
  logic [33:0]  c_q[$];

  nv_pipe_muxn #(.WIDTH(32), .NCH(4), .SELW(2), .MODE(0)) u_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_pvld(a_vld), .in_prdy(a_rdy), .in_pd(a_pd), .sel(a_sel),
    .out_pvld(a_ovld), .out_prdy(a_ordy), .out_pd(a_opd), .out_sel(a_osel));

  nv_pipe_muxn #(.WIDTH(32), .NCH(3), .SELW(2), .MODE(0)) u_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_pvld(b_vld), .in_prdy(b_rdy), .in_pd(b_pd), .sel(b_sel),
    .out_pvld(b_ovld), .out_prdy(b_ordy), .out_pd(b_opd), .out_sel(b_osel));

  nv_pipe_muxn #(.WIDTH(32), .NCH(4), .SELW(2), .MODE(1)) u_c (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_pvld(c_vld), .in_prdy(c_rdy), .in_pd(c_pd), .sel(c_sel),
    .out_pvld(c_ovld), .out_prdy(c_ordy), .out_pd(c_opd), .out_sel(c_osel));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic test_reset();
    rstn = 1'b0;
    a_vld = 4'hF; b_vld = 3'h7; c_vld = 4'hF;
    a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
    a_sel = 2'd2; b_sel = 2'd0; c_sel = 2'd0;
    a_pd = '0; b_pd = '0; c_pd = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (a_ovld !== 1'b0) begin bad++; $display("FAIL rst_ovld got=%b exp=0", a_ovld); end
    total++; if (a_opd !== 32'h0) begin bad++; $display("FAIL rst_opd got=%h exp=0", a_opd); end
    total++; if (a_osel !== 2'd0) begin bad++; $display("FAIL rst_osel got=%0d exp=0", a_osel); end
    total++; if (a_rdy !== 4'h0) begin bad++; $display("FAIL rst_a_rdy got=%b exp=0000", a_rdy); end
    total++; if (b_rdy !== 3'h0) begin bad++; $display("FAIL rst_b_rdy got=%b exp=000", b_rdy); end
    total++; if (c_rdy !== 4'h0) begin bad++; $display("FAIL rst_c_rdy got=%b exp=0000", c_rdy); end
    total++; if (c_ovld !== 1'b0) begin bad++; $display("FAIL rst_c_ovld got=%b exp=0", c_ovld); end
    @(negedge clk);
    rstn = 1'b1;
    a_vld = 4'b0100; a_pd[2*32 +: 32] = 32'hA5A5_0002;
    b_vld = 3'b000; c_vld = 4'b0000;
    #1;
    total++; if (a_rdy !== 4'b0100) begin bad++; $display("FAIL rel_rdy got=%b exp=0100", a_rdy); end
    @(posedge clk); #1;
    total++; if (a_ovld !== 1'b1) begin bad++; $display("FAIL rel_ovld got=%b exp=1", a_ovld); end
    total++; if (a_opd !== 32'hA5A5_0002) begin bad++; $display("FAIL rel_opd got=%h exp=a5a50002", a_opd); end
    total++; if (a_osel !== 2'd2) begin bad++; $display("FAIL rel_osel got=%0d exp=2", a_osel); end
    @(negedge clk);
    a_vld = 4'b0000;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a_sel = 2'd1; a_ordy = 1'b1; a_vld = 4'b0010;
      a_pd[1*32 +: 32] = 32'(i);
      #1;
      total++; if (a_rdy !== 4'b0010) begin bad++; $display("FAIL b2b_rdy[%0d] got=%b exp=0010", i, a_rdy); end
      @(posedge clk); #1;
      total++; if (a_ovld !== 1'b1) begin bad++; $display("FAIL b2b_ovld[%0d] got=%b exp=1", i, a_ovld); end
      total++; if (a_opd !== 32'(i)) begin bad++; $display("FAIL b2b_opd[%0d] got=%0h exp=%0h", i, a_opd, i); end
      total++; if (a_osel !== 2'd1) begin bad++; $display("FAIL b2b_osel[%0d] got=%0d exp=1", i, a_osel); end
    end
    @(negedge clk);
    a_vld = 4'b0000;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_sel = 2'd1; a_vld = 4'b0010; a_ordy = 1'b1; a_pd[1*32 +: 32] = 32'h11;
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      a_ordy = 1'b0; a_vld = 4'b1010; a_pd[3*32 +: 32] = 32'h33;
      a_sel = (n == 0) ? 2'd1 : 2'd3;
      #1;
      total++; if (a_rdy !== 4'b0000) begin bad++; $display("FAIL bp_rdy[%0d] got=%b exp=0000", n, a_rdy); end
      total++; if (a_opd !== 32'h11) begin bad++; $display("FAIL bp_opd[%0d] got=%h exp=11", n, a_opd); end
      total++; if (a_ovld !== 1'b1) begin bad++; $display("FAIL bp_ovld[%0d] got=%b exp=1", n, a_ovld); end
    end
    @(negedge clk);
    a_ordy = 1'b1;
    #1;
    total++; if (a_rdy !== 4'b1000) begin bad++; $display("FAIL bp_rel_rdy got=%b exp=1000", a_rdy); end
    @(posedge clk); #1;
    total++; if (a_ovld !== 1'b1) begin bad++; $display("FAIL bp_rel_ovld got=%b exp=1", a_ovld); end
    total++; if (a_opd !== 32'h33) begin bad++; $display("FAIL bp_rel_opd got=%h exp=33", a_opd); end
    total++; if (a_osel !== 2'd3) begin bad++; $display("FAIL bp_rel_osel got=%0d exp=3", a_osel); end
    @(negedge clk);
    a_vld = 4'b0000;
    @(posedge clk); #1;
    total++; if (a_ovld !== 1'b0) begin bad++; $display("FAIL bp_drain_ovld got=%b exp=0", a_ovld); end
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    b_sel = 2'd0; b_vld = 3'b111; b_ordy = 1'b1; b_pd = {3{32'h77}};
    @(posedge clk); #1;
    total++; if (b_ovld !== 1'b1) begin bad++; $display("FAIL inv_fill_ovld got=%b exp=1", b_ovld); end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      b_sel = 2'd3;
      #1;
      total++; if (b_rdy !== 3'b000) begin bad++; $display("FAIL inv_rdy[%0d] got=%b exp=000", n, b_rdy); end
      @(posedge clk); #1;
      total++; if (b_ovld !== 1'b0) begin bad++; $display("FAIL inv_ovld[%0d] got=%b exp=0", n, b_ovld); end
    end
    @(negedge clk);
    b_vld = 3'b000;
  endtask

  task automatic test_random_sel();
    logic [3:0] er;
    logic       load;
    @(negedge clk);
    a_vld = 4'b0000; a_ordy = 1'b1;
    @(negedge clk);
    a_q.delete();
    repeat (200) begin
      @(negedge clk);
      a_vld  = 4'($urandom_range(0, 15));
      a_sel  = 2'($urandom_range(0, 3));
      a_ordy = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < 4; ch++) a_pd[ch*32 +: 32] = $urandom;
      #1;
      load = (a_q.size() == 0) || a_ordy;
      er = 4'b0000;
      if (load) er[a_sel] = 1'b1;
      total++; if (a_rdy !== er) begin bad++; $display("FAIL rsel_rdy got=%b exp=%b", a_rdy, er); end
      total++; if (a_ovld !== (a_q.size() != 0)) begin bad++; $display("FAIL rsel_ovld got=%b exp=%0d", a_ovld, a_q.size()); end
      if (a_q.size() != 0) begin
        total++; if ({a_osel, a_opd} !== a_q[0]) begin bad++; $display("FAIL rsel_data got=%h exp=%h", {a_osel, a_opd}, a_q[0]); end
      end
      if (a_ordy && a_q.size() != 0) void'(a_q.pop_front());
      if (load && a_vld[a_sel]) a_q.push_back({a_sel, a_pd[a_sel*32 +: 32]});
    end
    @(negedge clk);
    a_vld = 4'b0000; a_ordy = 1'b1;
  endtask

  task automatic test_rr_fairness();
    @(negedge clk);
    c_vld = 4'hF; c_ordy = 1'b1;
    for (int ch = 0; ch < 4; ch++) c_pd[ch*32 +: 32] = 32'hC0 + 32'(ch);
    for (int n = 0; n < 7; n++) begin
      @(posedge clk); #1;
      total++; if (c_osel !== 2'(n % 4)) begin bad++; $display("FAIL rr_all_osel[%0d] got=%0d exp=%0d", n, c_osel, n % 4); end
      total++; if (c_opd !== 32'hC0 + 32'(n % 4)) begin bad++; $display("FAIL rr_all_opd[%0d] got=%h exp=%h", n, c_opd, 32'hC0 + 32'(n % 4)); end
    end
    @(negedge clk);
    c_vld = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      total++; if (c_osel !== ((n % 2 == 0) ? 2'd0 : 2'd2)) begin bad++; $display("FAIL rr_02_osel[%0d] got=%0d exp=%0d", n, c_osel, (n % 2 == 0) ? 0 : 2); end
    end
    @(negedge clk);
    c_vld = 4'b0000;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    c_vld = 4'b0010; c_ordy = 1'b0; c_pd[1*32 +: 32] = 32'hDEAD_0001;
    @(posedge clk); #1;
    total++; if (c_ovld !== 1'b1) begin bad++; $display("FAIL ar_pre_ovld got=%b exp=1", c_ovld); end
    #2 rstn = 1'b0;
    #1;
    total++; if (c_ovld !== 1'b0) begin bad++; $display("FAIL ar_ovld got=%b exp=0", c_ovld); end
    total++; if (c_opd !== 32'h0) begin bad++; $display("FAIL ar_opd got=%h exp=0", c_opd); end
    c_vld = 4'hF; c_ordy = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    total++; if (c_osel !== 2'd0) begin bad++; $display("FAIL ar_restart0 got=%0d exp=0", c_osel); end
    @(posedge clk); #1;
    total++; if (c_osel !== 2'd1) begin bad++; $display("FAIL ar_restart1 got=%0d exp=1", c_osel); end
    @(negedge clk);
    c_vld = 4'b0000;
  endtask

  task automatic test_rr_random();
    logic [3:0] er;
    logic       load;
    logic       found;
    int         rr;
    int         c;
    @(negedge clk);
    rstn = 1'b0;
    #2 rstn = 1'b1;
    c_q.delete();
    rr = 0;
    repeat (200) begin
      @(negedge clk);
      c_vld  = 4'($urandom_range(0, 15));
      c_ordy = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < 4; ch++) c_pd[ch*32 +: 32] = $urandom;
      #1;
      load  = (c_q.size() == 0) || c_ordy;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && c_vld[(rr + k) % 4]) begin
          found = 1'b1;
          c     = (rr + k) % 4;
        end
      end
      er = (load && found) ? 4'(1 << c) : 4'b0000;
      total++; if (c_rdy !== er) begin bad++; $display("FAIL rrr_rdy got=%b exp=%b", c_rdy, er); end
      total++; if (c_ovld !== (c_q.size() != 0)) begin bad++; $display("FAIL rrr_ovld got=%b exp=%0d", c_ovld, c_q.size()); end
      if (c_q.size() != 0) begin
        total++; if ({c_osel, c_opd} !== c_q[0]) begin bad++; $display("FAIL rrr_data got=%h exp=%h", {c_osel, c_opd}, c_q[0]); end
      end
      if (c_ordy && c_q.size() != 0) void'(c_q.pop_front());
      if (load && found) begin
        c_q.push_back({2'(c), c_pd[c*32 +: 32]});
        rr = (c + 1) % 4;
      end
    end
    @(negedge clk);
    c_vld = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_invalid_sel();
    test_random_sel();
    test_rr_fairness();
    test_async_reset();
    test_rr_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
